gray_step_ctrl: RTL and testbench

- Command-driven sequencer for the 3-bit Gray-code counter datapath (counter has Clk/Reset/En inputs and Output/Overflow outputs).
- Accepts step, clear and wrap commands over a valid/ready handshake.
- Drives the counter's enable and reset, tracks completed steps, and flags wrap-around.
- Sits between the control logic issuing counting jobs and one counter instance.

---
 rtl/gray_step_ctrl.sv | 151 +++++++++++++++
 tb/tb_gray_step_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_ctrl.sv
// Command sequencer for one 3-bit Gray-code counter: STEP/CLEAR/WRAP over valid/ready.
// Optional Gray-sequence checker is compiled in with `define GRAY_CHECK_EN.
module gray_step_ctrl #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [1:0]       Cmd_Op,
  input  logic [LEN_W-1:0] Cmd_Len,
  output logic             Cnt_En,
  output logic             Cnt_Reset,
  input  logic [2:0]       Cnt_Code,
  output logic             Busy,
  output logic             Done,
  output logic [LEN_W-1:0] Steps_Done,
  output logic             Wrapped,
  output logic             Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WRAP,
    S_CLR,
    S_FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_STEP  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_WRAP  = 2'b11
  } op_t;

  state_t           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] steps_q;
  logic [LEN_W-1:0] steps_d;
  logic             wrapped_q;
  op_t              op;

  assign op = op_t'(Cmd_Op);

  // Enable is masked by Reset so the counter never sees enable and reset together.
  assign Cnt_En    = ((state_q == S_RUN) || (state_q == S_WRAP)) && !Reset;
  assign Cnt_Reset = Reset || (state_q == S_CLR);
  assign Cmd_Ready = (state_q == S_IDLE);
  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_FIN);
  assign Steps_Done = steps_q;
  assign Wrapped    = wrapped_q;

  always_comb begin
    steps_d = steps_q;
    if (steps_q != '1) steps_d = steps_q + LEN_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      steps_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      if (Cnt_En && (Cnt_Code == 3'b100)) wrapped_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (Cmd_Valid) begin
            unique case (op)
              OP_NOP: state_q <= S_FIN;
              OP_STEP: begin
                steps_q <= '0;
                rem_q   <= Cmd_Len;
                state_q <= (Cmd_Len == '0) ? S_FIN : S_RUN;
              end
              OP_CLEAR: begin
                steps_q <= '0;
                state_q <= S_CLR;
              end
              OP_WRAP: begin
                steps_q <= '0;
                state_q <= S_WRAP;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_RUN: begin
          steps_q <= steps_d;
          rem_q   <= rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_q <= S_FIN;
        end
        S_WRAP: begin
          steps_q <= steps_d;
          if (Cnt_Code == 3'b100) state_q <= S_FIN;
        end
        S_CLR: begin
          steps_q   <= '0;
          wrapped_q <= 1'b0;
          state_q   <= S_FIN;
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef GRAY_CHECK_EN
  logic [2:0] prev_q;
  logic       chk_q;
  logic       err_q;
  logic [2:0] diff;
  logic       one_bit;

  function automatic logic [2:0] gray_succ(input logic [2:0] c);
    unique case (c)
      3'b000:  gray_succ = 3'b001;
      3'b001:  gray_succ = 3'b011;
      3'b011:  gray_succ = 3'b010;
      3'b010:  gray_succ = 3'b110;
      3'b110:  gray_succ = 3'b111;
      3'b111:  gray_succ = 3'b101;
      3'b101:  gray_succ = 3'b100;
      default: gray_succ = 3'b000;
    endcase
  endfunction

  assign diff    = Cnt_Code ^ prev_q;
  assign one_bit = (diff != 3'b000) && ((diff & (diff - 3'd1)) == 3'b000);

  // The code sampled in an enabled cycle must advance by one Gray step in the next.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_q <= '0;
      chk_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      chk_q <= Cnt_En;
      if (Cnt_En) prev_q <= Cnt_Code;
      if (chk_q && (!one_bit || (Cnt_Code != gray_succ(prev_q)))) err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed bench for gray_step_ctrl with a behavioural Gray counter and result scoreboard.
module tb_gray_step_ctrl;

  localparam int unsigned LEN_W = 8;
`ifdef GRAY_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Cmd_Valid = 1'b0;
  logic             Cmd_Ready;
  logic [1:0]       Cmd_Op = 2'b00;
  logic [LEN_W-1:0] Cmd_Len = '0;
  logic             Cnt_En;
  logic             Cnt_Reset;
  logic [2:0]       Cnt_Code;
  logic             Busy;
  logic             Done;
  logic [LEN_W-1:0] Steps_Done;
  logic             Wrapped;
  logic             Err;

  logic             inject = 1'b0;
  int               passes = 0;
  int               total  = 0;

  typedef struct {
    logic [31:0] steps;
    logic [31:0] wrapped;
    logic [31:0] code;
    logic [31:0] en_cycles;
    logic [31:0] rst_cycles;
  } exp_t;

  exp_t sb[$];

  always #5 Clk = ~Clk;

  gray_step_ctrl #(.LEN_W(LEN_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Cmd_Valid (Cmd_Valid),
    .Cmd_Ready (Cmd_Ready),
    .Cmd_Op    (Cmd_Op),
    .Cmd_Len   (Cmd_Len),
    .Cnt_En    (Cnt_En),
    .Cnt_Reset (Cnt_Reset),
    .Cnt_Code  (Cnt_Code),
    .Busy      (Busy),
    .Done      (Done),
    .Steps_Done(Steps_Done),
    .Wrapped   (Wrapped),
    .Err       (Err)
  );

  function automatic logic [2:0] gnext(input logic [2:0] c);
    case (c)
      3'b000:  gnext = 3'b001;
      3'b001:  gnext = 3'b011;
      3'b011:  gnext = 3'b010;
      3'b010:  gnext = 3'b110;
      3'b110:  gnext = 3'b111;
      3'b111:  gnext = 3'b101;
      3'b101:  gnext = 3'b100;
      default: gnext = 3'b000;
    endcase
  endfunction

  // Counter model; inject corrupts the 001 step into 010.
  always @(posedge Clk) begin
    if (Cnt_Reset)   Cnt_Code <= 3'b000;
    else if (Cnt_En) Cnt_Code <= (inject && Cnt_Code == 3'b001) ? 3'b010 : gnext(Cnt_Code);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int steps, input int wr, input int code, input int en, input int rst);
    exp_t e;
    e.steps = steps; e.wrapped = wr; e.code = code; e.en_cycles = en; e.rst_cycles = rst;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_ready", Cmd_Ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_steps", Steps_Done, 0);
    chk("rst_wrapped", Wrapped, 0);
    chk("rst_err", Err, 0);
    chk("rst_cnt_en", Cnt_En, 0);
    chk("rst_cnt_reset", Cnt_Reset, 1);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_code", Cnt_Code, 0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len, input bit poke);
    int en_cnt;
    int rst_cnt;
    bit got;
    exp_t e;
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Op = op; Cmd_Len = len;
    @(posedge Clk);
    #1;
    if (poke) Cmd_Op = 2'b10;
    else Cmd_Valid = 1'b0;
    en_cnt = 0; rst_cnt = 0; got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge Clk);
      if (Cnt_En) en_cnt++;
      if (Cnt_Reset) rst_cnt++;
      if (Done) got = 1;
    end
    Cmd_Valid = 1'b0;
    chk("done_seen", got, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("steps_done", Steps_Done, e.steps);
      chk("wrapped", Wrapped, e.wrapped);
      chk("code", Cnt_Code, e.code);
      chk("en_cycles", en_cnt, e.en_cycles);
      chk("rst_cycles", rst_cnt, e.rst_cycles);
    end
    @(negedge Clk);
    chk("done_one_cycle", Done, 0);
    chk("ready_after", Cmd_Ready, 1);
    chk("busy_after", Busy, 0);
  endtask

  initial begin
    do_reset();

    push(5, 0, 3'b111, 5, 0);
    run_cmd(2'b01, 8'd5, 1'b0);
    push(5, 0, 3'b111, 0, 0);
    run_cmd(2'b00, 8'd0, 1'b0);
    push(0, 0, 3'b111, 0, 0);
    run_cmd(2'b01, 8'd0, 1'b0);
    push(4, 1, 3'b001, 4, 0);
    run_cmd(2'b01, 8'd4, 1'b1);

    do_reset();
    push(10, 1, 3'b011, 10, 0);
    run_cmd(2'b01, 8'd10, 1'b0);

    do_reset();
    push(3, 0, 3'b010, 3, 0);
    run_cmd(2'b01, 8'd3, 1'b0);
    push(5, 1, 3'b000, 5, 0);
    run_cmd(2'b11, 8'd0, 1'b0);
    chk("err_clean", Err, 0);
    push(0, 0, 3'b000, 0, 1);
    run_cmd(2'b10, 8'd0, 1'b0);

    // Reset in the middle of a long STEP.
    @(negedge Clk);
    Cmd_Valid = 1'b1; Cmd_Op = 2'b01; Cmd_Len = 8'd200;
    @(posedge Clk);
    #1 Cmd_Valid = 1'b0;
    begin
      int en_cnt;
      en_cnt = 0;
      for (int i = 0; i < 50 && en_cnt < 7; i++) begin
        @(negedge Clk);
        if (Cnt_En) en_cnt++;
      end
      chk("mid_en_count", en_cnt, 7);
    end
    chk("mid_steps", Steps_Done, 6);
    Reset = 1'b1;
    #1;
    chk("mid_en_masked", Cnt_En, 0);
    chk("mid_cnt_reset", Cnt_Reset, 1);
    @(negedge Clk);
    chk("mid_busy", Busy, 0);
    chk("mid_en_after", Cnt_En, 0);
    chk("mid_rst_after", Cnt_Reset, 1);
    chk("mid_steps_clr", Steps_Done, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("mid_ready", Cmd_Ready, 1);
    chk("mid_rst_rel", Cnt_Reset, 0);
    chk("mid_code", Cnt_Code, 0);

    inject = 1'b1;
    push(3, 0, 3'b110, 3, 0);
    run_cmd(2'b01, 8'd3, 1'b0);
    inject = 1'b0;
    chk("err_set", Err, CHK);
    push(0, 0, 3'b000, 0, 1);
    run_cmd(2'b10, 8'd0, 1'b0);
    chk("err_sticky", Err, CHK);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
